mont_prod: RTL and testbench

//  Word-serial radix-2 Montgomery multiplier: result = A*B*R^-1 mod M, with R = 2^(OPW*length).

---
 rtl/mont_prod_if.sv | 28 ++
 rtl/mont_prod.sv | 194 +++++++++++++++++++
 tb/tb_mont_prod.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/mont_prod_if.sv
// rtl/mont_prod_if.sv - control and operand/result memory bus of the Montgomery product engine
interface mont_prod_if #(
    parameter int OPW = 32,
    parameter int ADW = 8
);
    logic [ADW-1:0] length;
    logic           calculate;
    logic           ready;
    logic [ADW-1:0] opa_addr;
    logic [OPW-1:0] opa_data;
    logic [ADW-1:0] opb_addr;
    logic [OPW-1:0] opb_data;
    logic [ADW-1:0] opm_addr;
    logic [OPW-1:0] opm_data;
    logic [ADW-1:0] result_addr;
    logic [OPW-1:0] result_data;
    logic           result_we;

    modport master (
        output length, calculate, opa_data, opb_data, opm_data,
        input  ready, opa_addr, opb_addr, opm_addr, result_addr, result_data, result_we
    );

    modport slave (
        input  length, calculate, opa_data, opb_data, opm_data,
        output ready, opa_addr, opb_addr, opm_addr, result_addr, result_data, result_we
    );
endinterface

// File: rtl/mont_prod.sv
// rtl/mont_prod.sv - word-serial radix-2 Montgomery multiplier, result = A*B*R^-1 mod M
// MONT_PROD_FINAL_SUB_EN adds the final conditional subtraction (result in [0, M) instead of [0, 2M)).
module mont_prod #(
    parameter int OPW = 32,
    parameter int ADW = 8
) (
    input  logic       clk,
    input  logic       reset,
    mont_prod_if.slave bus
);
    localparam int NW = 2 ** ADW;
    localparam int BW = ADW + 5;

    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_LOOP, ST_SUB, ST_WRITE} state_t;

    state_t         r_state;
    state_t         w_state_nx;
    logic [ADW-1:0] r_len;
    logic [ADW-1:0] r_j;
    logic [BW-1:0]  r_bit;
    logic           r_qphase;
    logic           r_abit;
    logic           r_q;
    logic [1:0]     r_carry;
    logic [OPW-2:0] r_prev;
    logic [OPW-1:0] r_s [NW];
    logic           r_result_we;
    logic [ADW-1:0] r_result_addr;
    logic [OPW-1:0] r_result_data;

    logic [ADW-1:0] w_jrev;
    logic           w_jlast;
    logic           w_bitlast;
    logic           w_abit;
    logic           w_q;
    logic [OPW-1:0] w_bword;
    logic [OPW-1:0] w_qmword;
    logic [OPW-1:0] w_sel_word;
    logic [OPW+1:0] w_sum;

`ifdef MONT_PROD_FINAL_SUB_EN
    logic [OPW-1:0] r_d [NW];
    logic           r_borrow;
    logic           r_use_d;
    logic [OPW-1:0] w_mword;
    logic [OPW:0]   w_diff;
`endif

    // S is held LSB word first (index 0); memories are MSB word first, hence the reversed address.
    assign w_jrev    = r_len - ADW'(1) - r_j;
    assign w_jlast   = (r_j == r_len);
    assign w_bitlast = (r_bit[4:0] == 5'd31) && (r_bit[BW-1:5] == r_len - ADW'(1));
    assign w_abit    = bus.opa_data[r_bit[4:0]];
    assign w_q       = r_s[0][0] ^ (w_abit & bus.opb_data[0]);
    assign w_bword   = (r_abit && !w_jlast) ? bus.opb_data : '0;
    assign w_qmword  = (r_q && !w_jlast) ? bus.opm_data : '0;
    assign w_sum     = {2'b00, r_s[r_j]} + {2'b00, w_bword} + {2'b00, w_qmword}
                     + {{OPW{1'b0}}, r_carry};

`ifdef MONT_PROD_FINAL_SUB_EN
    assign w_mword    = w_jlast ? '0 : bus.opm_data;
    assign w_diff     = {1'b0, r_s[r_j]} - {1'b0, w_mword} - {{OPW{1'b0}}, r_borrow};
    assign w_sel_word = r_use_d ? r_d[w_jrev] : r_s[w_jrev];
`else
    assign w_sel_word = r_s[w_jrev];
`endif

    assign bus.ready       = (r_state == ST_IDLE);
    assign bus.result_we   = r_result_we;
    assign bus.result_addr = r_result_addr;
    assign bus.result_data = r_result_data;

    always_comb begin
        bus.opa_addr = '0;
        bus.opb_addr = '0;
        bus.opm_addr = '0;
        if (r_state == ST_LOOP) begin
            if (r_qphase) begin
                bus.opa_addr = r_len - ADW'(1) - r_bit[BW-1:5];
                bus.opb_addr = r_len - ADW'(1);
            end else if (!w_jlast) begin
                bus.opb_addr = w_jrev;
                bus.opm_addr = w_jrev;
            end
        end else if (r_state == ST_SUB && !w_jlast) begin
            bus.opm_addr = w_jrev;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (bus.calculate && bus.length != '0) w_state_nx = ST_INIT;
            ST_INIT:  w_state_nx = ST_LOOP;
            ST_LOOP: begin
                if (!r_qphase && w_jlast && w_bitlast) begin
`ifdef MONT_PROD_FINAL_SUB_EN
                    w_state_nx = ST_SUB;
`else
                    w_state_nx = ST_WRITE;
`endif
                end
            end
            ST_SUB:   if (w_jlast) w_state_nx = ST_WRITE;
            ST_WRITE: if (w_jlast) w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_len         <= '0;
            r_j           <= '0;
            r_bit         <= '0;
            r_qphase      <= 1'b0;
            r_abit        <= 1'b0;
            r_q           <= 1'b0;
            r_carry       <= '0;
            r_prev        <= '0;
            r_result_we   <= 1'b0;
            r_result_addr <= '0;
            r_result_data <= '0;
            for (int k = 0; k < NW; k++) r_s[k] <= '0;
`ifdef MONT_PROD_FINAL_SUB_EN
            r_borrow      <= 1'b0;
            r_use_d       <= 1'b0;
`endif
        end else begin
            r_result_we <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.calculate) r_len <= bus.length;
                ST_INIT: begin
                    for (int k = 0; k < NW; k++) r_s[k] <= '0;
                    r_bit    <= '0;
                    r_j      <= '0;
                    r_carry  <= '0;
                    r_qphase <= 1'b1;
                end
                ST_LOOP: begin
                    if (r_qphase) begin
                        r_abit   <= w_abit;
                        r_q      <= w_q;
                        r_qphase <= 1'b0;
                        r_j      <= '0;
                        r_carry  <= '0;
                    end else begin
                        // Shift right by one on the fly: word j-1 takes bit 0 of word j as its MSB.
                        r_prev  <= w_sum[OPW-1:1];
                        r_carry <= w_sum[OPW+1:OPW];
                        if (r_j != '0) r_s[r_j - ADW'(1)] <= {w_sum[0], r_prev};
                        if (w_jlast) begin
                            r_s[r_len] <= w_sum[OPW:1];
                            r_bit      <= r_bit + BW'(1);
                            r_qphase   <= 1'b1;
                            r_j        <= '0;
                            r_carry    <= '0;
`ifdef MONT_PROD_FINAL_SUB_EN
                            r_borrow   <= 1'b0;
`endif
                        end else begin
                            r_j <= r_j + ADW'(1);
                        end
                    end
                end
`ifdef MONT_PROD_FINAL_SUB_EN
                ST_SUB: begin
                    r_d[r_j] <= w_diff[OPW-1:0];
                    r_borrow <= w_diff[OPW];
                    if (w_jlast) begin
                        r_use_d <= ~w_diff[OPW];
                        r_j     <= '0;
                    end else begin
                        r_j <= r_j + ADW'(1);
                    end
                end
`endif
                ST_WRITE: begin
                    if (!w_jlast) begin
                        r_result_we   <= 1'b1;
                        r_result_addr <= r_j;
                        r_result_data <= w_sel_word;
                        r_j           <= r_j + ADW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_prod.sv
// tb/tb_mont_prod.sv - directed self-checking bench for mont_prod
module tb_mont_prod;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mont_prod_if bus ();

    mont_prod dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] mem_a   [0:255];
    logic [31:0] mem_b   [0:255];
    logic [31:0] mem_m   [0:255];
    logic [31:0] res_mem [0:255];
    logic [7:0]  wr_log  [0:63];

    assign bus.opa_data = mem_a[bus.opa_addr];
    assign bus.opb_data = mem_b[bus.opb_addr];
    assign bus.opm_data = mem_m[bus.opm_addr];

    int n_checks = 0;
    int n_errors = 0;
    int wr_cnt = 0;
    int cyc_ctr = 0;
    int last_we_cyc = 0;

    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    always @(negedge clk) begin
        if (bus.result_we === 1'b1) begin
            res_mem[bus.result_addr] = bus.result_data;
            if (wr_cnt < 64) wr_log[wr_cnt] = bus.result_addr;
            wr_cnt = wr_cnt + 1;
            last_we_cyc = cyc_ctr;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit-serial reference on whole integers: returns S before the final conditional subtraction.
    function automatic logic [127:0] mont_raw(input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] m, input int len);
        logic [127:0] s;
        s = '0;
        for (int i = 0; i < 32 * len; i++) begin
            if (a[i]) s = s + {64'b0, b};
            if (s[0]) s = s + {64'b0, m};
            s = s >> 1;
        end
        return s;
    endfunction

    function automatic logic [63:0] mont_reduced(input logic [63:0] a, input logic [63:0] b,
                                                 input logic [63:0] m, input int len);
        logic [127:0] s;
        s = mont_raw(a, b, m, len);
        if (s >= {64'b0, m}) s = s - {64'b0, m};
        return s[63:0];
    endfunction

    function automatic logic [63:0] expect_val(input logic [63:0] hand, input logic [63:0] a,
                                               input logic [63:0] b, input logic [63:0] m,
                                               input int len);
        logic [127:0] s;
        s = mont_raw(a, b, m, len);
`ifdef MONT_PROD_FINAL_SUB_EN
        s = {64'b0, hand};
`endif
        return s[63:0];
    endfunction

    task automatic load_ops(input int len, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] m);
        for (int w = 0; w < len; w++) begin
            mem_a[len-1-w] = a[32*w +: 32];
            mem_b[len-1-w] = b[32*w +: 32];
            mem_m[len-1-w] = m[32*w +: 32];
        end
        for (int w = 0; w < 4; w++) res_mem[w] = 32'hdeadbeef;
    endtask

    task automatic run_op(input string tag, input int len, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] m,
                          input logic [63:0] hand, input int poke);
        logic [63:0] exp;
        int cyc;
        int bound;
        int base;
        exp = expect_val(hand, a, b, m, len);
        load_ops(len, a, b, m);
        base = wr_cnt;
        bound = 32 * len * (2 * len + 4) + 4 * len + 8;
        bus.length = len[7:0];
        bus.calculate = 1'b1;
        @(negedge clk);
        bus.calculate = 1'b0;
        check($sformatf("%s_busy", tag), {63'b0, bus.ready}, 64'd0);
        cyc = 1;
        while (bus.ready !== 1'b1 && cyc <= bound) begin
            if (cyc == poke) begin
                bus.length = 8'd2;
                bus.calculate = 1'b1;
            end else begin
                bus.calculate = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.calculate = 1'b0;
        check($sformatf("%s_latency", tag), {63'b0, cyc <= bound}, 64'd1);
        check($sformatf("%s_nwrites", tag), 64'(wr_cnt - base), 64'(len));
        for (int k = 0; k < len; k++) begin
            if (base + k < 64) check($sformatf("%s_order%0d", tag, k), {56'b0, wr_log[base+k]}, 64'(k));
            check($sformatf("%s_word%0d", tag, k), {32'b0, res_mem[k]}, {32'b0, exp[32*(len-1-k) +: 32]});
        end
        check($sformatf("%s_ready_after_last", tag), 64'(cyc_ctr - last_we_cyc), 64'd1);
    endtask

    initial begin
        int base;
        reset = 1'b1;
        bus.calculate = 1'b0;
        bus.length = 8'd0;
        for (int k = 0; k < 256; k++) begin
            mem_a[k] = '0;
            mem_b[k] = '0;
            mem_m[k] = '0;
            res_mem[k] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_ready", {63'b0, bus.ready}, 64'd1);
        check("rst_we", {63'b0, bus.result_we}, 64'd0);
        check("rst_opa_addr", {56'b0, bus.opa_addr}, 64'd0);
        check("rst_opb_addr", {56'b0, bus.opb_addr}, 64'd0);
        check("rst_opm_addr", {56'b0, bus.opm_addr}, 64'd0);
        check("rst_res_addr", {56'b0, bus.result_addr}, 64'd0);
        check("rst_res_data", {32'b0, bus.result_data}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("v9x7", 1, 64'h9, 64'h7, 64'h13, 64'h1, 0);
        run_op("vbx2", 1, 64'hb, 64'h2, 64'h11, 64'h5, 0);
        run_op("v11x7", 1, 64'h11, 64'h7, 64'h13, 64'h4, 0);
        run_op("v11x13", 1, 64'h11, 64'h13, 64'h10001, 64'h143, 0);
        run_op("v20002", 1, 64'h20002, 64'h22, 64'h7fffffff, 64'h220022, 0);
        run_op("v8000", 1, 64'h8000, 64'h11, 64'h10001, 64'h7ff8, 0);
        run_op("rinv2", 2, 64'h1, 64'h1, 64'h0000000b_00000001, 64'h79, 0);
        run_op("mix2", 2, 64'h00000005_00000003, 64'h00000007_00000009, 64'h0000000b_00000001,
               mont_reduced(64'h00000005_00000003, 64'h00000007_00000009, 64'h0000000b_00000001, 2), 0);

        run_op("poke", 1, 64'h11, 64'h7, 64'h13, 64'h4, 5);
        base = wr_cnt;
        repeat (4) @(negedge clk);
        check("poke_idle_ready", {63'b0, bus.ready}, 64'd1);
        check("poke_no_extra_wr", 64'(wr_cnt - base), 64'd0);

        base = wr_cnt;
        bus.length = 8'd0;
        bus.calculate = 1'b1;
        @(negedge clk);
        bus.calculate = 1'b0;
        check("len0_ready", {63'b0, bus.ready}, 64'd1);
        repeat (5) @(negedge clk);
        check("len0_ready_hold", {63'b0, bus.ready}, 64'd1);
        check("len0_no_writes", 64'(wr_cnt - base), 64'd0);

        load_ops(1, 64'h9, 64'h7, 64'h13);
        bus.length = 8'd1;
        bus.calculate = 1'b1;
        @(negedge clk);
        bus.calculate = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_busy", {63'b0, bus.ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_ready", {63'b0, bus.ready}, 64'd1);
        check("abort_we", {63'b0, bus.result_we}, 64'd0);
        reset = 1'b0;
        base = wr_cnt;
        repeat (150) @(negedge clk);
        check("abort_no_writes", 64'(wr_cnt - base), 64'd0);
        check("abort_ready_hold", {63'b0, bus.ready}, 64'd1);

        run_op("recover", 1, 64'h8000, 64'h11, 64'h10001, 64'h7ff8, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
